complex_shifter: RTL

- Parametrised, pipelined successor to the fixed halve-by-two complex scaler in the message path.
- Each packed complex sample {re, im} is arithmetically right-shifted by a run-time programmable amount, with sign extension.
- Each result is saturated to a configurable output width, and a count of saturated samples is kept.
- Sits between FFT/filter stages and the message packer, where it sets the gain headroom.

---
 rtl/complex_shifter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/complex_shifter.sv
`default_nettype none
// ============================================================================
// Module   : complex_shifter
// Brief    : Two-stage complex {re, im} arithmetic right shifter with saturation,
//            saturated-sample counter and sticky illegal-shift flag.
//            Define COMPLEX_SHIFTER_ROUND_EN for round-half-up (default truncates).
// Revision : 1.0 - initial release
// ============================================================================
module complex_shifter #(
    parameter int WIDTH       = 32,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 4,
    parameter int RESET_SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_nd,
    input  logic [SHIFT_WIDTH-1:0] shift_in,
    input  logic                   shift_load,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_nd,
    output logic [15:0]            sat_count,
    output logic                   error
);

    localparam int c_hw          = WIDTH / 2;
    localparam int c_ohw         = OUT_WIDTH / 2;
    localparam int c_max_shift_i = c_hw - 1;
    localparam logic [SHIFT_WIDTH-1:0] c_max_shift = SHIFT_WIDTH'(c_max_shift_i);
    localparam logic [SHIFT_WIDTH-1:0] c_reset_shift = SHIFT_WIDTH'(RESET_SHIFT);
    // Saturation bounds expressed in the (c_hw+1)-bit guarded domain
    localparam logic signed [c_hw:0] c_sat_max = {{(c_hw - c_ohw + 2){1'b0}}, {(c_ohw - 1){1'b1}}};
    localparam logic signed [c_hw:0] c_sat_min = {{(c_hw - c_ohw + 2){1'b1}}, {(c_ohw - 1){1'b0}}};
`ifdef COMPLEX_SHIFTER_ROUND_EN
    localparam logic [c_hw:0] c_one = {{c_hw{1'b0}}, 1'b1};
`endif

    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [SHIFT_WIDTH-1:0] r_sh1;
    logic [c_hw-1:0]        r_re1;
    logic [c_hw-1:0]        r_im1;
    logic                   r_v1;
    logic                   w_illegal;
    logic [c_ohw-1:0]       w_re_out;
    logic [c_ohw-1:0]       w_im_out;
    logic                   w_sat_re;
    logic                   w_sat_im;

    function automatic logic [c_ohw-1:0] scale(
        input  logic [c_hw-1:0]        x,
        input  logic [SHIFT_WIDTH-1:0] s,
        output logic                   sat
    );
        logic signed [c_hw:0] v;
        v = $signed({x[c_hw-1], x});
`ifdef COMPLEX_SHIFTER_ROUND_EN
        if (s != '0)
            v = v + $signed(c_one << (s - SHIFT_WIDTH'(1)));
`endif
        v = v >>> s;
        sat = 1'b1;
        if (v > c_sat_max)
            scale = c_sat_max[c_ohw-1:0];
        else if (v < c_sat_min)
            scale = c_sat_min[c_ohw-1:0];
        else begin
            scale = v[c_ohw-1:0];
            sat   = 1'b0;
        end
    endfunction

    assign w_illegal = (32'(shift_in) > 32'(c_max_shift_i));

    // Stage 1 captures the shift currently in force, so a same-cycle load
    // only affects later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= c_reset_shift;
            error   <= 1'b0;
            r_v1    <= 1'b0;
            r_re1   <= '0;
            r_im1   <= '0;
            r_sh1   <= '0;
        end else begin
            r_v1 <= in_nd;
            if (in_nd) begin
                r_re1 <= in_data[WIDTH-1:c_hw];
                r_im1 <= in_data[c_hw-1:0];
                r_sh1 <= r_shift;
            end
            if (shift_load) begin
                r_shift <= w_illegal ? c_max_shift : shift_in;
                if (w_illegal)
                    error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_sat_re = 1'b0;
        w_sat_im = 1'b0;
        w_re_out = scale(r_re1, r_sh1, w_sat_re);
        w_im_out = scale(r_im1, r_sh1, w_sat_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_nd    <= 1'b0;
            sat_count <= '0;
        end else begin
            out_nd <= r_v1;
            if (r_v1) begin
                out_data <= {w_re_out, w_im_out};
                if ((w_sat_re || w_sat_im) && (sat_count != 16'hFFFF))
                    sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
